arb_ffd4: RTL

Two-requester round-robin arbiter that shares one WIDTH-bit D-flip-flop register between requesters A and B. Each requester asks for ownership with a request line, receives a registered grant, writes its data into the shared register while granted, and releases by dropping its request. It sits between the lab FSM blocks, which act as producers, and the shared register datapath, and is the only path through which that register is written.

---
 rtl/arb_pkg.sv | 14 +
 rtl/ffd_en_reg.sv | 33 +++
 rtl/arb_ffd4.sv | 136 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared encodings for the two-requester register arbiter.
// Latency: n/a (types and constants only). Backpressure: n/a.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } arb_state_e;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/ffd_en_reg.sv
// WIDTH-bit D flip-flop with load enable and asynchronous active-low clear.
// Latency: load visible one cycle after en. Backpressure: none, en is a plain strobe.
module ffd_en_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/arb_ffd4.sv
// Round-robin arbiter granting A or B sole write access to a shared WIDTH-bit register.
// Latency: grant 1 cycle after req, write 1 cycle after wr; IDLE gap of >=1 cycle between grants.
// Backpressure: requester holds req until gnt; ARB_TIMEOUT_EN adds a forced release after MAX_TENURE cycles.
module arb_ffd4
    import arb_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MAX_TENURE = 8
) (
    input  logic             clock,
    input  logic             RST,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             wr_a,
    input  logic             wr_b,
    input  logic [WIDTH-1:0] d_a,
    input  logic [WIDTH-1:0] d_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             owner
);

    if (MAX_TENURE < 2) begin : g_bad_tenure
        $error("arb_ffd4: MAX_TENURE must be at least 2");
    end

    arb_state_e state_d;
    arb_state_e state_q;
    logic       owner_d;
    logic       owner_q;
    logic       wr_en;
    logic [WIDTH-1:0] wr_dat;

`ifdef ARB_TIMEOUT_EN
    localparam int TEN_W = $clog2(MAX_TENURE);
    localparam logic [TEN_W-1:0] TEN_MAX = TEN_W'(MAX_TENURE - 1);

    logic [TEN_W-1:0] tenure_d;
    logic [TEN_W-1:0] tenure_q;
    logic             expire_a;
    logic             expire_b;

    // A full tenure only ends early when the other side is actually waiting.
    assign expire_a = (tenure_q == TEN_MAX) && req_b;
    assign expire_b = (tenure_q == TEN_MAX) && req_a;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_a && (!req_b || owner_q == OWN_B)) begin
                    state_d = ST_GNT_A;
                    owner_d = OWN_A;
                end else if (req_b) begin
                    state_d = ST_GNT_B;
                    owner_d = OWN_B;
                end
            end
            ST_GNT_A: begin
                if (!req_a) begin
                    state_d = ST_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (expire_a) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_GNT_B: begin
                if (!req_b) begin
                    state_d = ST_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (expire_b) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    // Counts edges spent granted, saturating; any path back to IDLE clears it.
    always_comb begin
        tenure_d = '0;
        if (state_q != ST_IDLE && state_d != ST_IDLE) begin
            tenure_d = (tenure_q == TEN_MAX) ? tenure_q : tenure_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge RST) begin
        if (!RST) begin
            tenure_q <= '0;
        end else begin
            tenure_q <= tenure_d;
        end
    end
`endif

    always_ff @(posedge clock or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_B;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign gnt_a = (state_q == ST_GNT_A);
    assign gnt_b = (state_q == ST_GNT_B);
    assign busy  = gnt_a | gnt_b;
    assign owner = owner_q;

    // Gating with req drops the write that coincides with a voluntary release.
    assign wr_en  = (gnt_a & req_a & wr_a) | (gnt_b & req_b & wr_b);
    assign wr_dat = gnt_a ? d_a : d_b;

    ffd_en_reg #(
        .WIDTH (WIDTH)
    ) u_shared_reg (
        .clk   (clock),
        .rst_n (RST),
        .en    (wr_en),
        .d     (wr_dat),
        .q     (q)
    );

endmodule
